// File: rtl/riscv_pc_fetch.sv
// riscv_pc_fetch: program counter and instruction fetch unit for the RV32I core.
// Sequence: fetch request (S_FETCH), wait for the word (S_WAIT), hold it for
// decode (S_ISSUE), then compute the next PC from the one-hot PC opcode.
// A stop opcode, a malformed opcode or a misaligned target parks the unit in
// S_HALT until reset.
// Optional feature: define RV_FETCH_COUNT_EN to add the 64-bit retired_cnt output.
// PC opcode bit positions: [0] PcStop, [1] PcIncr, [2] PcJAL, [3] PcJALR, [4] PcBranch.
module riscv_pc_fetch #(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rstn,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   output logic            instr_valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] link_addr,
   input  logic            pc_op_valid,
   input  logic [4:0]      pc_op,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] imm,
   input  logic [XLEN-1:0] rs1,
   output logic            halted,
   output logic            illegal_op,
   output logic            misalign
`ifdef RV_FETCH_COUNT_EN
   ,
   output logic [63:0]     retired_cnt
`endif
);

   localparam logic [4:0] PC_STOP   = 5'b00001;
   localparam logic [4:0] PC_INCR   = 5'b00010;
   localparam logic [4:0] PC_JAL    = 5'b00100;
   localparam logic [4:0] PC_JALR   = 5'b01000;
   localparam logic [4:0] PC_BRANCH = 5'b10000;

   localparam logic [XLEN-1:0] PC_STEP   = XLEN'(3'd4);
   localparam logic [XLEN-1:0] JALR_MASK = ~(XLEN'(1'b1));

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_ISSUE = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   state_t            state_r;
   logic [XLEN-1:0]   pc_r;
   logic [31:0]       instr_r;
   logic              instr_valid_r;
   logic              req_valid_r;
   logic              halted_r;
   logic              illegal_r;
   logic              misalign_r;

   logic [XLEN-1:0]   link_s;
   logic [XLEN-1:0]   jump_s;
   logic [XLEN-1:0]   jalr_s;
   logic [XLEN-1:0]   next_pc_s;
   logic              one_hot_s;
   logic              retire_s;

   // Next-PC candidates, opcode sanity and the "advance normally" decision.
   always_comb begin
      link_s    = pc_r + PC_STEP;
      jump_s    = pc_r + imm;
      jalr_s    = (rs1 + imm) & JALR_MASK;
      one_hot_s = (pc_op != 5'b00000) && ((pc_op & (pc_op - 5'b00001)) == 5'b00000);
      next_pc_s = pc_r;
      case (pc_op)
         PC_INCR:   next_pc_s = link_s;
         PC_JAL:    next_pc_s = jump_s;
         PC_JALR:   next_pc_s = jalr_s;
         PC_BRANCH: begin
            if (branch_taken) begin
               next_pc_s = jump_s;
            end else begin
               next_pc_s = link_s;
            end
         end
         default:   next_pc_s = pc_r;
      endcase
      // Stop and malformed opcodes leave next_pc_s = pc, so only the opcode
      // checks matter for them; every other opcode must also land word-aligned.
      retire_s = (state_r == S_ISSUE) && pc_op_valid && one_hot_s &&
                 (pc_op != PC_STOP) && (next_pc_s[1:0] == 2'b00);
   end

   // Fetch / issue state machine with all handshake and status outputs registered.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_r       <= S_FETCH;
         pc_r          <= RESET_VEC;
         instr_r       <= 32'h0000_0000;
         instr_valid_r <= 1'b0;
         req_valid_r   <= 1'b1;
         halted_r      <= 1'b0;
         illegal_r     <= 1'b0;
         misalign_r    <= 1'b0;
      end else begin
         case (state_r)
            S_FETCH: begin
               if (imem_req_ready) begin
                  req_valid_r <= 1'b0;
                  state_r     <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rsp_valid) begin
                  instr_r       <= imem_rsp_data;
                  instr_valid_r <= 1'b1;
                  state_r       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (pc_op_valid) begin
                  instr_valid_r <= 1'b0;
                  if (retire_s) begin
                     pc_r        <= next_pc_s;
                     req_valid_r <= 1'b1;
                     state_r     <= S_FETCH;
                  end else begin
                     halted_r <= 1'b1;
                     state_r  <= S_HALT;
                     if (!one_hot_s) begin
                        illegal_r <= 1'b1;
                     end else if (pc_op != PC_STOP) begin
                        misalign_r <= 1'b1;
                     end
                  end
               end
            end
            S_HALT: begin
               halted_r      <= 1'b1;
               instr_valid_r <= 1'b0;
               req_valid_r   <= 1'b0;
            end
            default: begin
               // Unreachable encoding: fail safe into the halted state.
               halted_r      <= 1'b1;
               instr_valid_r <= 1'b0;
               req_valid_r   <= 1'b0;
               state_r       <= S_HALT;
            end
         endcase
      end
   end

`ifdef RV_FETCH_COUNT_EN
   logic [63:0] retired_cnt_r;

   // Count every opcode that actually advanced the PC.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         retired_cnt_r <= 64'd0;
      end else if (retire_s) begin
         retired_cnt_r <= retired_cnt_r + 64'd1;
      end
   end

   assign retired_cnt = retired_cnt_r;
`endif

   assign imem_req_valid = req_valid_r;
   assign imem_req_addr  = pc_r;
   assign instr_valid    = instr_valid_r;
   assign instr          = instr_r;
   assign pc             = pc_r;
   assign link_addr      = link_s;
   assign halted         = halted_r;
   assign illegal_op     = illegal_r;
   assign misalign       = misalign_r;

endmodule
